// File: rtl/security_keypad_ctrl_pkg.sv
// Shared encodings for the keypad controller and the security FSM that consumes KEY.
package security_keypad_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_GRANT   = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  localparam logic [1:0] KEY_ARM    = 2'b11;
  localparam logic [1:0] KEY_DISARM = 2'b00;
  localparam logic [1:0] KEY_HOLD   = 2'b01;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-CLK-cycle TICK every TICK_DIV cycles.
module tick_gen #(
  parameter int TICK_DIV = 1_250_000
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      TICK <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/security_keypad_ctrl.sv
// PIN-entry controller: collects four digits, issues one-cycle arm/disarm commands,
// and locks the keypad out after repeated wrong PINs. All outputs are registered.
module security_keypad_ctrl
  import security_keypad_ctrl_pkg::*;
#(
  parameter int          TICK_DIV = 1_250_000,
  parameter logic [15:0] PIN      = 16'h1234,
  parameter int          ENTRY_TO = 500,
  parameter int          LOCK_TO  = 3000,
  parameter int          MAX_FAIL = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] DIG_IN,
  input  logic       DIG_STB,
  output logic [1:0] KEY,
  output logic       ARMED,
  output logic       LOCKED,
  output logic       ERR,
  output logic [2:0] DIG_CNT
);

  localparam int CNT_MAX = (ENTRY_TO > LOCK_TO) ? ENTRY_TO : LOCK_TO;
  localparam int TO_W    = $clog2(CNT_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam logic [TO_W-1:0]   ENTRY_LAST = TO_W'(ENTRY_TO - 1);
  localparam logic [TO_W-1:0]   LOCK_LAST  = TO_W'(LOCK_TO - 1);
  localparam logic [TO_W-1:0]   TO_SAT     = TO_W'(CNT_MAX);
  localparam logic [FAIL_W-1:0] FAIL_LIM   = FAIL_W'(MAX_FAIL);

  state_t              state_q, state_nxt;
  logic                tick;
  logic                stb_q;
  logic                press;
  logic                take;
  logic [15:0]         entry_q;
  logic [2:0]          dig_cnt_q;
  logic [FAIL_W-1:0]   fail_q;
  logic [TO_W-1:0]     to_q;
  logic [1:0]          key_q;
  logic                armed_q, locked_q, err_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

  // stb_q resets high so a strobe held through reset release is not a press
  assign press = DIG_STB & ~stb_q;
  assign take  = press & ((state_q == ST_IDLE) | (state_q == ST_ENTRY));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stb_q <= 1'b1;
    else     stb_q <= DIG_STB;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:    if (press) state_nxt = ST_ENTRY;
      // a press in the same cycle as the expiring tick wins over the timeout
      ST_ENTRY: begin
        if (press && dig_cnt_q == 3'd3)                  state_nxt = ST_CHECK;
        else if (!press && tick && to_q == ENTRY_LAST)   state_nxt = ST_IDLE;
      end
      ST_CHECK:   state_nxt = (entry_q == PIN) ? ST_GRANT : ST_FAIL;
      ST_GRANT:   state_nxt = ST_IDLE;
      ST_FAIL:    state_nxt = (fail_q + 1'b1 == FAIL_LIM) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (tick && to_q == LOCK_LAST) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      entry_q   <= '0;
      dig_cnt_q <= '0;
    end else if (take) begin
      entry_q   <= {entry_q[11:0], DIG_IN};
      dig_cnt_q <= dig_cnt_q + 3'd1;
    end else if ((state_q == ST_ENTRY && state_nxt == ST_IDLE) ||
                 state_q == ST_GRANT || state_q == ST_FAIL) begin
      entry_q   <= '0;
      dig_cnt_q <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                               fail_q <= '0;
    else if (state_q == ST_GRANT)                          fail_q <= '0;
    else if (state_q == ST_FAIL)                           fail_q <= fail_q + 1'b1;
    else if (state_q == ST_LOCKOUT && state_nxt == ST_IDLE) fail_q <= '0;
  end

  // Shared inactivity/lockout tick counter, restarted on every state change or accepted press
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                   to_q <= '0;
    else if (state_nxt != state_q || take)     to_q <= '0;
    else if (tick && to_q != TO_SAT)           to_q <= to_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_q    <= KEY_HOLD;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      key_q    <= (state_nxt == ST_GRANT) ? (armed_q ? KEY_DISARM : KEY_ARM) : KEY_HOLD;
      armed_q  <= armed_q ^ (state_nxt == ST_GRANT);
      locked_q <= (state_nxt == ST_LOCKOUT);
      err_q    <= (state_nxt == ST_FAIL);
    end
  end

  assign KEY     = key_q;
  assign ARMED   = armed_q;
  assign LOCKED  = locked_q;
  assign ERR     = err_q;
  assign DIG_CNT = dig_cnt_q;

endmodule

// File: tb/tb_security_keypad_ctrl.sv
// Randomized self-checking bench for security_keypad_ctrl with a transaction-level reference model.
module tb_security_keypad_ctrl;
  import security_keypad_ctrl_pkg::*;

  localparam int          TD   = 4;
  localparam int          ETO  = 10;
  localparam int          LTO  = 20;
  localparam int          MF   = 3;
  localparam logic [15:0] PINV = 16'h1234;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] DIG_IN = 4'd0;
  logic       DIG_STB = 1'b0;
  logic [1:0] KEY;
  logic       ARMED, LOCKED, ERR;
  logic [2:0] DIG_CNT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int key_seen = 0;
  int err_seen = 0;

  // reference model: armed status and consecutive wrong-PIN count
  bit m_armed = 1'b0;
  int m_fails = 0;

  always #5 CLK = ~CLK;

  security_keypad_ctrl #(
    .TICK_DIV (TD),
    .PIN      (PINV),
    .ENTRY_TO (ETO),
    .LOCK_TO  (LTO),
    .MAX_FAIL (MF)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIG_IN  (DIG_IN),
    .DIG_STB (DIG_STB),
    .KEY     (KEY),
    .ARMED   (ARMED),
    .LOCKED  (LOCKED),
    .ERR     (ERR),
    .DIG_CNT (DIG_CNT)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (KEY != KEY_HOLD) key_seen <= key_seen + 1;
      if (ERR)             err_seen <= err_seen + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge CLK);
    DIG_IN  = d;
    DIG_STB = 1'b1;
    @(negedge CLK);
    DIG_STB = 1'b0;
  endtask

  task automatic lockout_phase();
    int t0, kb, eb;
    kb = key_seen;
    eb = err_seen;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      press(4'($urandom_range(0, 9)));
      check_val("lock_dig_cnt", 32'(DIG_CNT), 0);
      idle(1);
    end
    while (2 + cyc - t0 < 74) @(negedge CLK);
    check_val("locked_hold", 32'(LOCKED), 1);
    while (2 + cyc - t0 < 84) @(negedge CLK);
    check_val("locked_release", 32'(LOCKED), 0);
    check_val("lock_key_pulses", 32'(key_seen - kb), 0);
    check_val("lock_err_pulses", 32'(err_seen - eb), 0);
    m_fails = 0;
  endtask

  task automatic attempt(input logic [15:0] code);
    int kb, eb;
    bit ok;
    kb = key_seen;
    eb = err_seen;
    ok = (code == PINV);
    for (int i = 0; i < 3; i++) begin
      press(code[15-4*i -: 4]);
      check_val("dig_cnt", 32'(DIG_CNT), 32'(i + 1));
      idle($urandom_range(0, 5));
    end
    press(code[3:0]);
    check_val("dig_cnt4", 32'(DIG_CNT), 4);
    check_val("key_in_check", 32'(KEY), 32'(KEY_HOLD));
    @(negedge CLK);
    if (ok) begin
      check_val("key_grant", 32'(KEY), m_armed ? 32'(KEY_DISARM) : 32'(KEY_ARM));
      check_val("err_grant", 32'(ERR), 0);
      m_armed = !m_armed;
      m_fails = 0;
    end else begin
      check_val("err_fail", 32'(ERR), 1);
      check_val("key_fail", 32'(KEY), 32'(KEY_HOLD));
      m_fails++;
    end
    idle(2);
    check_val("armed", 32'(ARMED), 32'(m_armed));
    check_val("dig_cnt_end", 32'(DIG_CNT), 0);
    check_val("key_pulses", 32'(key_seen - kb), ok ? 32'd1 : 32'd0);
    check_val("err_pulses", 32'(err_seen - eb), ok ? 32'd0 : 32'd1);
    check_val("locked", 32'(LOCKED), 32'(m_fails == MF));
    if (m_fails == MF) lockout_phase();
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) c = {c[11:0], 4'($urandom_range(0, 9))};
    return c;
  endfunction

  initial begin
    int kb, eb, nt, guard;
    logic [15:0] code;

    idle(3);
    check_val("rst_key", 32'(KEY), 32'(KEY_HOLD));
    check_val("rst_armed", 32'(ARMED), 0);
    check_val("rst_locked", 32'(LOCKED), 0);
    check_val("rst_err", 32'(ERR), 0);
    check_val("rst_dig_cnt", 32'(DIG_CNT), 0);
    RST = 1'b0;
    idle(3);

    attempt(PINV);
    attempt(PINV);
    attempt(16'h9999);
    attempt(16'h9999);

    // abandoned entry times out without touching the fail count
    eb = err_seen;
    press(4'd1);
    press(4'd2);
    idle(30);
    check_val("to_pending", 32'(DIG_CNT), 2);
    idle(30);
    check_val("to_expired", 32'(DIG_CNT), 0);
    check_val("to_no_err", 32'(err_seen - eb), 0);
    attempt(16'h9999);
    attempt(PINV);

    // press lands on the tick that would otherwise expire the entry
    press(4'd1);
    nt = 0;
    guard = 0;
    while (nt < ETO && guard < 200) begin
      if (dut.u_tick.TICK) nt++;
      if (nt < ETO) begin
        @(negedge CLK);
        guard++;
      end
    end
    check_val("tick_align", 32'(nt), 32'(ETO));
    DIG_IN  = 4'd2;
    DIG_STB = 1'b1;
    @(negedge CLK);
    DIG_STB = 1'b0;
    check_val("coinc_dig_cnt", 32'(DIG_CNT), 2);
    idle(60);
    check_val("coinc_later_to", 32'(DIG_CNT), 0);

    // asynchronous reset in the middle of an entry
    if (!m_armed) attempt(PINV);
    kb = key_seen;
    press(4'd1);
    press(4'd2);
    @(negedge CLK);
    DIG_IN  = 4'd3;
    DIG_STB = 1'b1;
    #2 RST = 1'b1;
    #1;
    check_val("arst_key", 32'(KEY), 32'(KEY_HOLD));
    check_val("arst_armed", 32'(ARMED), 0);
    check_val("arst_locked", 32'(LOCKED), 0);
    check_val("arst_err", 32'(ERR), 0);
    check_val("arst_dig_cnt", 32'(DIG_CNT), 0);
    idle(2);
    RST = 1'b0;
    idle(4);
    check_val("held_stb_ignored", 32'(DIG_CNT), 0);
    check_val("arst_no_key", 32'(key_seen - kb), 0);
    DIG_STB = 1'b0;
    m_armed = 1'b0;
    m_fails = 0;
    attempt(PINV);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 9) < 4) begin
        code = PINV;
      end else begin
        code = rand_code();
        while (code == PINV) code = rand_code();
      end
      attempt(code);
      idle($urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
